run_length_counter: RTL and testbench

- Pipelined, parametrised leading-run counter for the posit decode path.
- Counts leading ones, leading zeros, or the MSB-polarity run. MSB-polarity mode gives the posit regime run length.
- Replaces ad-hoc combinational leading-ones counters.
- Valid/ready streaming interface; full throughput (one word per cycle) and fixed latency.

---
 rtl/run_length_counter.sv | 162 ++++++++++++++++
 tb/tb_run_length_counter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_counter.sv
`default_nettype none
// ============================================================================
// run_length_counter : pipelined leading-run counter (leading 0s / 1s / MSB run)
// Optional feature macro: RLC_TAG_EN (sideband tag travels with each word)
// Revision: 1.0
// ============================================================================
module run_length_counter #(
   parameter int N       = 8,
   parameter int LATENCY = 1,
   parameter int C       = $clog2(N + 1)
`ifdef RLC_TAG_EN
   ,
   parameter int TAG_W   = 4
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_bits,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [C-1:0]     out_count,
   output logic             out_all,
   output logic [C-1:0]     out_index,
   output logic             out_pol
`ifdef RLC_TAG_EN
   ,
   input  logic [TAG_W-1:0] in_tag,
   output logic [TAG_W-1:0] out_tag
`endif
);

   localparam int LW = N / 2;

   // Length of the run of ones in m[hi:lo], starting at m[hi].
   function automatic logic [C-1:0] lead_run(input logic [N-1:0] m, input int hi, input int lo);
      logic [C-1:0] cnt;
      logic         run;
      cnt = '0;
      run = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (i <= hi && i >= lo) begin
            if (run && m[i]) cnt = cnt + C'(1);
            else             run = 1'b0;
         end
      end
      return cnt;
   endfunction

   logic         pol_in;
   logic [N-1:0] match_in;

   always_comb begin
      pol_in   = in_mode[1] ? in_bits[N-1] : in_mode[0];
      match_in = pol_in ? in_bits : ~in_bits;
   end

   logic         ld_out;
   logic         fin_valid;
   logic [C-1:0] fin_cnt;
   logic         fin_pol;
   logic         fin_all;
   logic [C-1:0] fin_index;
`ifdef RLC_TAG_EN
   logic [TAG_W-1:0] fin_tag;
`endif

   assign ld_out    = !out_valid || out_ready;
   assign fin_all   = (fin_cnt == C'(N));
   assign fin_index = fin_all ? '0 : C'(N - 1) - fin_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_count <= '0;
         out_all   <= 1'b0;
         out_index <= '0;
         out_pol   <= 1'b0;
`ifdef RLC_TAG_EN
         out_tag   <= '0;
`endif
      end else if (ld_out) begin
         out_valid <= fin_valid;
         if (fin_valid) begin
            out_count <= fin_cnt;
            out_all   <= fin_all;
            out_index <= fin_index;
            out_pol   <= fin_pol;
`ifdef RLC_TAG_EN
            out_tag   <= fin_tag;
`endif
         end
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         localparam int UW = N - LW;

         logic         ld_s1;
         logic         s1_valid;
         logic         s1_pol;
         logic         s1_up_all;
         logic [C-1:0] s1_up;
         logic [C-1:0] s1_lo;
         logic [C-1:0] up_cnt;
         logic [C-1:0] lo_cnt;
`ifdef RLC_TAG_EN
         logic [TAG_W-1:0] s1_tag;
`endif

         assign up_cnt   = lead_run(match_in, N - 1, LW);
         assign lo_cnt   = lead_run(match_in, LW - 1, 0);
         assign ld_s1    = !s1_valid || ld_out;
         assign in_ready = ld_s1;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_valid  <= 1'b0;
               s1_pol    <= 1'b0;
               s1_up_all <= 1'b0;
               s1_up     <= '0;
               s1_lo     <= '0;
`ifdef RLC_TAG_EN
               s1_tag    <= '0;
`endif
            end else if (ld_s1) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_up     <= up_cnt;
                  s1_lo     <= lo_cnt;
                  s1_up_all <= (up_cnt == C'(UW));
                  s1_pol    <= pol_in;
`ifdef RLC_TAG_EN
                  s1_tag    <= in_tag;
`endif
               end
            end
         end

         // The lower half only extends the run when the whole upper half matched.
         assign fin_valid = s1_valid;
         assign fin_cnt   = s1_up_all ? s1_up + s1_lo : s1_up;
         assign fin_pol   = s1_pol;
`ifdef RLC_TAG_EN
         assign fin_tag   = s1_tag;
`endif
      end else begin : g_lat1
         assign in_ready  = ld_out;
         assign fin_valid = in_valid;
         assign fin_cnt   = lead_run(match_in, N - 1, 0);
         assign fin_pol   = pol_in;
`ifdef RLC_TAG_EN
         assign fin_tag   = in_tag;
`endif
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_run_length_counter.sv
`default_nettype none
// Bench for run_length_counter: three instances (N=8/L=1, N=16/L=2, N=8/L=2).
module tb_run_length_counter;

   localparam int NA = 8;
   localparam int NB = 16;
   localparam int NC = 8;
   localparam int LA = 1;
   localparam int LB = 2;
   localparam int LC = 2;
   localparam int CA = $clog2(NA + 1);
   localparam int CB = $clog2(NB + 1);
   localparam int CC = $clog2(NC + 1);
   localparam int TW = 4;
`ifdef RLC_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]    cnt;
      logic [7:0]    idx;
      logic          all;
      logic          pol;
      logic [TW-1:0] tag;
   } res_t;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] bits;
      int         cnt;
      int         idx;
      bit         all;
      bit         pol;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic a_iv = 0, a_ir, a_ov, a_or = 1, a_all, a_pol;
   logic [NA-1:0] a_bits = '0;
   logic [1:0]    a_mode = '0;
   logic [CA-1:0] a_cnt, a_idx;
   logic [TW-1:0] a_tin = '0, a_tout;

   logic b_iv = 0, b_ir, b_ov, b_or = 1, b_all, b_pol;
   logic [NB-1:0] b_bits = '0;
   logic [1:0]    b_mode = '0;
   logic [CB-1:0] b_cnt, b_idx;
   logic [TW-1:0] b_tin = '0, b_tout;

   logic c_iv = 0, c_ir, c_ov, c_or = 1, c_all, c_pol;
   logic [NC-1:0] c_bits = '0;
   logic [1:0]    c_mode = '0;
   logic [CC-1:0] c_cnt, c_idx;
   logic [TW-1:0] c_tin = '0, c_tout;

   run_length_counter #(.N(NA), .LATENCY(LA)
`ifdef RLC_TAG_EN
      , .TAG_W(TW)
`endif
   ) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_bits(a_bits),
      .in_mode(a_mode), .out_valid(a_ov), .out_ready(a_or), .out_count(a_cnt),
      .out_all(a_all), .out_index(a_idx), .out_pol(a_pol)
`ifdef RLC_TAG_EN
      , .in_tag(a_tin), .out_tag(a_tout)
`endif
   );

   run_length_counter #(.N(NB), .LATENCY(LB)
`ifdef RLC_TAG_EN
      , .TAG_W(TW)
`endif
   ) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_bits(b_bits),
      .in_mode(b_mode), .out_valid(b_ov), .out_ready(b_or), .out_count(b_cnt),
      .out_all(b_all), .out_index(b_idx), .out_pol(b_pol)
`ifdef RLC_TAG_EN
      , .in_tag(b_tin), .out_tag(b_tout)
`endif
   );

   run_length_counter #(.N(NC), .LATENCY(LC)
`ifdef RLC_TAG_EN
      , .TAG_W(TW)
`endif
   ) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_bits(c_bits),
      .in_mode(c_mode), .out_valid(c_ov), .out_ready(c_or), .out_count(c_cnt),
      .out_all(c_all), .out_index(c_idx), .out_pol(c_pol)
`ifdef RLC_TAG_EN
      , .in_tag(c_tin), .out_tag(c_tout)
`endif
   );

`ifndef RLC_TAG_EN
   assign a_tout = '0;
   assign b_tout = '0;
   assign c_tout = '0;
`endif

   // Reference: walk down from the MSB while bits equal the selected polarity.
   function automatic res_t model(input logic [15:0] b, input logic [1:0] m, input int n,
                                  input logic [TW-1:0] tg);
      res_t r;
      int   k;
      logic p;
      p = m[1] ? b[n-1] : m[0];
      k = 0;
      while (k < n && b[n-1-k] == p) k++;
      r.cnt = 8'(k);
      r.all = (k == n);
      r.idx = (k == n) ? 8'd0 : 8'(n - 1 - k);
      r.pol = p;
      r.tag = TAG_EN ? tg : '0;
      return r;
   endfunction

   function automatic res_t pack(input int cnt, input int idx, input logic all, input logic pol,
                                 input logic [TW-1:0] tg);
      res_t r;
      r.cnt = 8'(cnt);
      r.idx = 8'(idx);
      r.all = all;
      r.pol = pol;
      r.tag = tg;
      return r;
   endfunction

   function automatic res_t pack_a();
      return pack(int'(a_cnt), int'(a_idx), a_all, a_pol, a_tout);
   endfunction
   function automatic res_t pack_b();
      return pack(int'(b_cnt), int'(b_idx), b_all, b_pol, b_tout);
   endfunction
   function automatic res_t pack_c();
      return pack(int'(c_cnt), int'(c_idx), c_all, c_pol, c_tout);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   res_t q_b[$];
   res_t q_c[$];
   vec_t tbl[10];

   initial begin
      res_t held;
      res_t e;
      bit   stall;
      int   sent, got, acc_edge, first_out, gap, stale, lat;

      tbl[0] = '{2'b01, 8'b1101_0000, 2, 5, 1'b0, 1'b1};
      tbl[1] = '{2'b00, 8'b0011_0000, 2, 5, 1'b0, 1'b0};
      tbl[2] = '{2'b00, 8'b0000_0000, 8, 0, 1'b1, 1'b0};
      tbl[3] = '{2'b01, 8'b1111_1111, 8, 0, 1'b1, 1'b1};
      tbl[4] = '{2'b01, 8'b0111_1000, 0, 7, 1'b0, 1'b1};
      tbl[5] = '{2'b10, 8'b1110_0000, 3, 4, 1'b0, 1'b1};
      tbl[6] = '{2'b11, 8'b0001_0110, 3, 4, 1'b0, 1'b0};
      tbl[7] = '{2'b10, 8'b1000_0001, 1, 6, 1'b0, 1'b1};
      tbl[8] = '{2'b00, 8'b1000_0000, 0, 7, 1'b0, 1'b0};
      tbl[9] = '{2'b11, 8'b1111_1111, 8, 0, 1'b1, 1'b1};

      // ---------------- reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_a_valid", a_ov, 0);
      chk("reset_a_data", pack_a(), 0);
      chk("reset_b_valid", b_ov, 0);
      chk("reset_c_data", {c_ov, pack_c()}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_in_ready", {a_ir, b_ir, c_ir}, 3'b111);

      // ---------------- directed table on N=8, L=1
      for (int i = 0; i < 10; i++) begin
         a_iv = 1'b1; a_bits = tbl[i].bits; a_mode = tbl[i].mode; a_tin = TW'(i);
         @(posedge clk);
         #1;
         a_iv = 1'b0;
         chk($sformatf("tbl%0d_valid", i), a_ov, 1);
         chk($sformatf("tbl%0d_result", i), pack_a(),
             pack(tbl[i].cnt, tbl[i].idx, tbl[i].all, tbl[i].pol, TAG_EN ? TW'(i) : '0));
      end
      @(posedge clk);
      #1;

      // ---------------- N=16, L=2 random stream at full throughput
      sent = 0; got = 0; acc_edge = -1; first_out = -1; gap = 0;
      for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
         if (sent < 20) begin
            b_iv = 1'b1; b_bits = 16'($urandom); b_mode = 2'($urandom); b_tin = TW'($urandom);
         end else b_iv = 1'b0;
         #1;
         if (b_ov) begin
            if (first_out < 0) first_out = cyc;
            if (q_b.size() == 0) chk("b_unexpected_result", 1, 0);
            else chk("b_stream_result", pack_b(), q_b.pop_front());
            got++;
         end else if (first_out >= 0) gap++;
         if (b_iv && b_ir) begin
            q_b.push_back(model(b_bits, b_mode, NB, b_tin));
            if (acc_edge < 0) acc_edge = cyc;
            sent++;
         end
         @(posedge clk);
         #1;
      end
      b_iv = 1'b0;
      chk("b_first_latency", first_out - acc_edge, LB);
      chk("b_no_gaps", gap, 0);
      chk("b_result_count", got, 20);

      // ---------------- N=8, L=2 backpressure
      c_or = 1'b0; sent = 0; stall = 1'b0;
      c_bits = 8'($urandom); c_mode = 2'($urandom); c_tin = TW'($urandom);
      for (int cyc = 0; cyc < 6; cyc++) begin
         c_iv = 1'b1;
         #1;
         if (c_ov) begin
            if (stall) chk("c_hold_stable", pack_c(), held);
            held = pack_c();
            stall = 1'b1;
         end
         if (c_ir) begin
            q_c.push_back(model(16'(c_bits), c_mode, NC, c_tin));
            sent++;
         end
         @(posedge clk);
         #1;
         if (c_ir == 1'b0 && sent > 0 && q_c.size() != 0) begin
            // keep the presented word while it is refused
         end
         if (sent != 0 && q_c.size() == sent && c_iv) begin
            c_bits = 8'($urandom); c_mode = 2'($urandom); c_tin = TW'($urandom);
         end
      end
      chk("c_accepted_two", sent, 2);
      chk("c_full_not_ready", c_ir, 0);
      chk("c_full_valid", c_ov, 1);

      // full pipeline with out_ready rising: accept and emit in the same cycle
      c_or = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 20 && (got < 3 || q_c.size() != 0); cyc++) begin
         c_iv = (cyc == 0);
         #1;
         if (cyc == 0) chk("c_full_accept", c_ir, 1);
         if (c_ov) begin
            if (q_c.size() == 0) chk("c_unexpected_result", 1, 0);
            else chk("c_drain_result", pack_c(), q_c.pop_front());
            got++;
         end
         if (c_iv && c_ir) q_c.push_back(model(16'(c_bits), c_mode, NC, c_tin));
         @(posedge clk);
         #1;
      end
      c_iv = 1'b0;
      chk("c_drain_count", got, 3);

      // ---------------- N=8, L=2 random valid/ready traffic
      sent = 0; stall = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         c_iv   = (sent < 80) && ($urandom_range(3) != 0);
         c_bits = 8'($urandom); c_mode = 2'($urandom); c_tin = TW'($urandom);
         c_or   = ($urandom_range(2) != 0);
         #1;
         if (stall) chk("c_rand_hold", {c_ov, pack_c()}, {1'b1, held});
         if (c_ov && c_or) begin
            if (q_c.size() == 0) chk("c_rand_unexpected", 1, 0);
            else chk("c_rand_result", pack_c(), q_c.pop_front());
         end
         stall = c_ov && !c_or;
         held  = pack_c();
         if (c_iv && c_ir) begin
            q_c.push_back(model(16'(c_bits), c_mode, NC, c_tin));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      c_iv = 1'b0;
      c_or = 1'b1;
      for (int cyc = 0; cyc < 10 && q_c.size() != 0; cyc++) begin
         #1;
         if (c_ov) chk("c_rand_tail", pack_c(), q_c.pop_front());
         @(posedge clk);
         #1;
      end
      chk("c_rand_all_delivered", q_c.size(), 0);

      // ---------------- asynchronous reset with two words in flight
      c_or = 1'b0;
      for (int i = 0; i < 2; i++) begin
         c_iv = 1'b1; c_bits = 8'($urandom); c_mode = 2'($urandom); c_tin = TW'($urandom);
         @(posedge clk);
         #1;
      end
      c_iv = 1'b0;
      chk("c_pre_reset_valid", c_ov, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("c_async_reset", {c_ov, pack_c()}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      c_or = 1'b1;
      stale = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         #1;
         if (c_ov) stale++;
         @(posedge clk);
         #1;
      end
      chk("c_no_stale", stale, 0);
      c_iv = 1'b1; c_bits = 8'b0000_0110; c_mode = 2'b11; c_tin = 4'hA;
      e = model(16'(c_bits), c_mode, NC, c_tin);
      #1;
      chk("c_post_reset_ready", c_ir, 1);
      @(posedge clk);
      #1;
      c_iv = 1'b0;
      lat = -1;
      for (int k = 0; k < 10 && lat < 0; k++) begin
         #1;
         if (c_ov) begin
            lat = k + 1;
            chk("c_post_reset_result", pack_c(), e);
         end
         @(posedge clk);
         #1;
      end
      chk("c_post_reset_latency", lat, LC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
